// File: rtl/serial_detector_scheduler.sv
// serial_detector_scheduler: round-robin sharing of one 110/101 serial detector
// between requesters A and B, returning a per-frame match count and bit mask.
module serial_detector_scheduler #(
   parameter int FRAME_W = 8,
   parameter int CNT_W = $clog2(FRAME_W + 1)
) (
   input  logic               clock,
   input  logic               reset_,
   input  logic               req_a,
   input  logic               req_b,
   input  logic [FRAME_W-1:0] frame_a,
   input  logic [FRAME_W-1:0] frame_b,
   output logic               ack_a,
   output logic               ack_b,
   output logic               det_clr,
   output logic               det_x,
   input  logic               det_z,
   output logic               done,
   output logic               res_id,
   output logic [CNT_W-1:0]   res_count,
   output logic [FRAME_W-1:0] res_mask
);
   localparam int IDX_W = $clog2(FRAME_W);
   typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;
   state_t state, state_d;
   logic last, last_d, grant_b, id, samp;
   logic ack_a_d, ack_b_d, det_clr_d, det_x_d, done_d;
   logic [FRAME_W-1:0] shreg, acc_mask;
   logic [CNT_W-1:0] acc_cnt;
   logic [IDX_W-1:0] idx;
   logic last_bit;

   assign grant_b = req_b && (!req_a || !last);
   assign last_bit = idx == IDX_W'(FRAME_W - 1);
   // z lags det_x by one edge, so sampling starts one SHIFT edge late and ends in DRAIN
   assign samp = (state == SHIFT && idx != '0) || state == DRAIN;

   always_ff @(posedge clock or posedge reset_)
      if (reset_) state <= IDLE;
      else state <= state_d;

   always_comb begin
      state_d = state;
      last_d = last;
      ack_a_d = 1'b0;
      ack_b_d = 1'b0;
      det_clr_d = 1'b0;
      det_x_d = 1'b0;
      done_d = 1'b0;
      case (state)
         IDLE: if (req_a || req_b) begin
            state_d = CLEAR;
            ack_a_d = !grant_b;
            ack_b_d = grant_b;
            det_clr_d = 1'b1;
            last_d = (req_a && req_b) ? grant_b : last;
         end
         CLEAR: begin
            state_d = SHIFT;
            det_x_d = shreg[FRAME_W-1];
         end
         SHIFT: begin
            state_d = last_bit ? DRAIN : SHIFT;
            det_x_d = last_bit ? 1'b0 : shreg[FRAME_W-1];
         end
         DRAIN: begin
            state_d = DONE;
            done_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset_)
      if (reset_) begin
         last <= 1'b1;
         ack_a <= 1'b0;
         ack_b <= 1'b0;
         det_clr <= 1'b1;
         det_x <= 1'b0;
         done <= 1'b0;
         res_id <= 1'b0;
         res_count <= '0;
         res_mask <= '0;
         id <= 1'b0;
         shreg <= '0;
         idx <= '0;
         acc_mask <= '0;
         acc_cnt <= '0;
      end else begin
         last <= last_d;
         ack_a <= ack_a_d;
         ack_b <= ack_b_d;
         det_clr <= det_clr_d;
         det_x <= det_x_d;
         done <= done_d;
         if (state == IDLE && (req_a || req_b)) begin
            shreg <= grant_b ? frame_b : frame_a;
            id <= grant_b;
         end else shreg <= shreg << 1;
         idx <= (state == SHIFT) ? idx + 1'b1 : '0;
         acc_mask <= (state == CLEAR) ? '0 : samp ? {acc_mask[FRAME_W-2:0], det_z} : acc_mask;
         acc_cnt <= (state == CLEAR) ? '0 : acc_cnt + CNT_W'(samp && det_z);
         if (done_d) begin
            res_id <= id;
            res_mask <= {acc_mask[FRAME_W-2:0], det_z};
            res_count <= acc_cnt + CNT_W'(det_z);
         end
      end
endmodule
